// File: rtl/feature_loader_pkg.sv
// Shared widths, FSM encoding and slice helper for the feature loader.
package feature_loader_pkg;

   // Index counter width, never narrower than one bit.
   function automatic int unsigned idx_bits(input int unsigned feat_cnt);
      return (feat_cnt > 1) ? $clog2(feat_cnt) : 1;
   endfunction

   // Hold counter width, wide enough to hold the value hold_cycles.
   function automatic int unsigned hold_bits(input int unsigned hold_cycles);
      return $clog2(hold_cycles + 1);
   endfunction

   // Bit offset of feature i inside the packed vector.
   function automatic int unsigned feat_slice(input int unsigned i, input int unsigned feat_bits);
      return i * feat_bits;
   endfunction

   localparam int unsigned FEAT_CNT_DFLT    = 4;
   localparam int unsigned FEAT_BITS_DFLT   = 4;
   localparam int unsigned HOLD_CYCLES_DFLT = 8;
   localparam int unsigned IDX_BITS         = idx_bits(FEAT_CNT_DFLT);
   localparam int unsigned HOLD_BITS        = hold_bits(HOLD_CYCLES_DFLT);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_e;

endpackage

// File: rtl/feature_loader_seq_if.sv
// Feature beat stream: one quantised feature per accepted beat.
interface feature_loader_seq_if #(
   parameter int unsigned FEAT_BITS = 4
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [FEAT_BITS-1:0] in_feat;

   modport master (output in_valid, output in_feat, input in_ready);
   modport slave  (input in_valid, input in_feat, output in_ready);
endinterface

// File: rtl/hold_timer.sv
// Hold down-counter: counts core cycles after the restart pulse is released,
// then emits a one-cycle expire pulse.
module hold_timer #(
   parameter int unsigned HOLD_CYCLES = 8,
   parameter int unsigned HOLD_BITS   = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic busy,
   output logic expire
);

   logic [HOLD_BITS-1:0] hold_cnt;
   logic                 skip;

   // Load on commit; the cycle the restart pulse is high does not count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
         skip     <= 1'b0;
         busy     <= 1'b0;
         expire   <= 1'b0;
      end else begin
         skip   <= load;
         expire <= 1'b0;
         if (load) begin
            hold_cnt <= HOLD_BITS'(HOLD_CYCLES);
            busy     <= 1'b1;
         end else if ((hold_cnt != '0) && !skip) begin
            hold_cnt <= hold_cnt - HOLD_BITS'(1);
            if (hold_cnt == HOLD_BITS'(1)) begin
               busy   <= 1'b0;
               expire <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/feature_loader_seq.sv
// Double-buffered feature loader in front of the sequential BNN core.
module feature_loader_seq
   import feature_loader_pkg::*;
#(
   parameter int unsigned FEAT_CNT    = 4,
   parameter int unsigned FEAT_BITS   = 4,
   parameter int unsigned HOLD_CYCLES = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   feature_loader_seq_if.slave           s_in,
   output logic [FEAT_CNT*FEAT_BITS-1:0] features,
   output logic                          features_valid,
   output logic                          core_rst,
   output logic                          result_valid,
   output logic                          busy
);

   localparam int unsigned IDX_W  = idx_bits(FEAT_CNT);
   localparam int unsigned HOLD_W = hold_bits(HOLD_CYCLES);
   localparam int unsigned VEC_W  = FEAT_CNT * FEAT_BITS;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FEAT_CNT - 1);

   state_e             state;
   logic [IDX_W-1:0]   idx;
   logic [VEC_W-1:0]   shadow;
   logic               in_ready_q;
   logic               accept_c;
   logic               commit_c;

   assign s_in.in_ready = in_ready_q;

   // Flush wins over any beat accept or commit in the same cycle.
   assign accept_c = (state == FILL) && s_in.in_valid && in_ready_q && !flush;
   assign commit_c = (state == FULL) && !busy && !flush;

   // Shadow fill, commit to the output register and restart pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= FILL;
         idx            <= '0;
         shadow         <= '0;
         in_ready_q     <= 1'b1;
         features       <= '0;
         features_valid <= 1'b0;
         core_rst       <= 1'b0;
      end else begin
         core_rst <= 1'b0;
         if (flush) begin
            idx        <= '0;
            shadow     <= '0;
            state      <= FILL;
            in_ready_q <= 1'b1;
         end else begin
            case (state)
               FILL: begin
                  if (accept_c) begin
                     shadow[feat_slice(32'(idx), FEAT_BITS) +: FEAT_BITS] <= s_in.in_feat;
                     if (idx == IDX_LAST) begin
                        idx        <= '0;
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                     end else begin
                        idx <= idx + IDX_W'(1);
                     end
                  end
               end
               FULL: begin
                  if (commit_c) begin
                     features       <= shadow;
                     features_valid <= 1'b1;
                     core_rst       <= 1'b1;
                     state          <= FILL;
                     in_ready_q     <= 1'b1;
                  end
               end
               default: state <= FILL;
            endcase
         end
      end
   end

   // Prediction-valid timer started by each commit.
   hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .HOLD_BITS   (HOLD_W)
   ) u_hold_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (commit_c),
      .busy   (busy),
      .expire (result_valid)
   );

endmodule
